// File: rtl/ysyx_24100005_defs.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// and a small alignment helper.
package ysyx_24100005_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_NEXT = 3'd3,
    S_ERR  = 3'd4
  } ifu_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic loadable register with synchronous active-high reset to a
// parameterised value.
module ysyx_24100005_Reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;

  always_comb begin
    if (wen) begin
      dout_d = din;
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RESET_VAL;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one fetch outstanding at a time, holds the fetched
// word until execute consumes it and supplies the next PC.
module ysyx_24100005_ifu
  import ysyx_24100005_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        pc_upd_valid,
  input  logic [31:0] pc_upd,
  output logic        fetch_err
);

  ifu_state_e  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] pc_q;
  logic        pc_wen;
  logic        pc_take;

  ysyx_24100005_Reg #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .din  (pc_upd),
    .wen  (pc_wen),
    .dout (pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      inst_q    <= 32'h0000_0000;
      inst_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // A next PC is taken only when execute has consumed (or is consuming) the held word.
  always_comb begin
    state_d = state_q;
    pc_take = 1'b0;
    case (state_q)
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
        else               state_d = S_REQ;
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_d = mem_rsp_err ? S_ERR : S_HOLD;
        else               state_d = S_WAIT;
      end
      S_HOLD: begin
        if (inst_ready && pc_upd_valid) begin
          pc_take = 1'b1;
          state_d = is_word_aligned(pc_upd) ? S_REQ : S_ERR;
        end else if (inst_ready) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_NEXT: begin
        if (pc_upd_valid) begin
          pc_take = 1'b1;
          state_d = is_word_aligned(pc_upd) ? S_REQ : S_ERR;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    pc_wen    = pc_take && is_word_aligned(pc_upd);
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if ((state_q == S_WAIT) && mem_rsp_valid && !mem_rsp_err) begin
      inst_d    = mem_rsp_data;
      inst_pc_d = pc_q;
    end else begin
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;
    fetch_err     = 1'b0;
    case (state_q)
      S_REQ:   mem_req_valid = 1'b1;
      S_HOLD:  inst_valid    = 1'b1;
      S_ERR:   fetch_err     = 1'b1;
      default: mem_req_valid = 1'b0;
    endcase
  end

  assign mem_req_addr = pc_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Randomised scoreboard bench for the fetch unit: a behavioural memory and
// execute-stage model predict handshakes and the fetched word stream.
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        pc_upd_valid = 1'b0;
  logic [31:0] pc_upd = 32'h0;
  logic        fetch_err;

  always #5 clk = ~clk;

  ysyx_24100005_ifu #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .pc_upd_valid  (pc_upd_valid),
    .pc_upd        (pc_upd),
    .fetch_err     (fetch_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: what the fetch unit should be doing, in protocol terms.
  logic [31:0] m_pc;
  logic        pend, pend_err, holding, owe, dead;
  logic [31:0] pend_addr, hold_pc;
  int          lat;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == RST_PC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; pend = 1'b0; pend_err = 1'b0; holding = 1'b0;
    owe = 1'b0; dead = 1'b0; pend_addr = 32'h0; hold_pc = RST_PC; lat = 0;
    sb.delete();
  endtask

  task automatic accept_pc(input logic [31:0] p);
    if (p[1:0] != 2'b00) dead = 1'b1;
    else m_pc = p;
  endtask

  // Leaves the bench at a negedge with rst just released.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; inst_ready = 1'b0; pc_upd_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("reset_inst", inst, 32'h0);
    check("reset_inst_pc", inst_pc, 32'h0);
  endtask

  task automatic step(input logic fast, input logic no_err);
    logic exp_req;
    int   r;
    exp_req = !dead && !pend && !holding && !owe;
    check("mem_req_valid", mem_req_valid, exp_req);
    check("inst_valid", inst_valid, holding);
    check("fetch_err", fetch_err, dead);
    if (exp_req) check("mem_req_addr", mem_req_addr, m_pc);

    mem_req_ready = fast ? 1'b1 : ($urandom_range(0, 9) < 7);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    mem_rsp_err   = 1'($urandom_range(0, 1));
    if (pend && lat == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memword(pend_addr);
      mem_rsp_err   = pend_err;
    end else if (exp_req && $urandom_range(0, 7) == 0) begin
      mem_rsp_valid = 1'b1;
    end
    inst_ready   = fast ? 1'b1 : 1'($urandom_range(0, 1));
    pc_upd_valid = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 99);
    if (r < 50)                      pc_upd = hold_pc + 32'd4;
    else if (r < 60)                 pc_upd = 32'hFFFF_FFFC;
    else if (r < (no_err ? 60 : 63)) pc_upd = ($urandom & 32'hFFFF_FFFC) | 32'd2;
    else                             pc_upd = $urandom & 32'hFFFF_FFFC;

    if (exp_req && mem_req_ready) begin
      pend      = 1'b1;
      pend_addr = m_pc;
      lat       = fast ? 0 : $urandom_range(0, 3);
      pend_err  = !no_err && ($urandom_range(0, 29) == 0);
      if (!pend_err) sb.push_back('{m_pc, memword(m_pc)});
    end else if (pend) begin
      if (lat == 0) begin
        pend = 1'b0;
        if (pend_err) dead = 1'b1;
        else begin
          holding = 1'b1;
          hold_pc = pend_addr;
        end
      end else begin
        lat--;
      end
    end else if (holding) begin
      if (inst_ready) begin
        holding = 1'b0;
        if (pc_upd_valid) accept_pc(pc_upd);
        else owe = 1'b1;
      end
    end else if (owe) begin
      if (pc_upd_valid) begin
        owe = 1'b0;
        accept_pc(pc_upd);
      end
    end
  endtask

  // Monitor: compares each consumed instruction against the scoreboard.
  initial begin
    logic        have_prev;
    logic        prev_v, prev_r;
    logic [31:0] prev_inst, prev_pc;
    exp_t        e;
    have_prev = 1'b0;
    prev_v = 1'b0; prev_r = 1'b0; prev_inst = 32'h0; prev_pc = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && prev_v && !prev_r && inst_valid) begin
          check("inst_stable", inst, prev_inst);
          check("inst_pc_stable", inst_pc, prev_pc);
        end
        if (inst_valid && inst_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_inst: got pc %h with no fetch outstanding", inst_pc);
          end else begin
            e = sb.pop_front();
            check("inst", inst, e.word);
            check("inst_pc", inst_pc, e.pc);
          end
        end
        prev_v = inst_valid; prev_r = inst_ready;
        prev_inst = inst; prev_pc = inst_pc;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    int dead_cycles;
    int rst_at;
    for (int ep = 0; ep < 12; ep++) begin
      do_reset(1 + ep % 3);
      dead_cycles = 0;
      rst_at = (ep % 3 == 2) ? $urandom_range(20, 150) : -1;
      for (int c = 0; c < 300; c++) begin
        if (c > 0) @(negedge clk);
        if (c == rst_at) break;
        step(ep == 0, ep < 2);
        if (dead) dead_cycles++;
        if (dead_cycles > 6) break;
      end
    end
    do_reset(1);
    step(1'b1, 1'b1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_ifu.md
YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

Interface
REQ-001 Parameter RESET_PC SHALL be declared: default 32'h8000_0000, the first fetch address after reset.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, reset; synchronous and active-high.
REQ-004 Port mem_req_valid SHALL be: output, 1 bit, fetch request to instruction memory.
REQ-005 Port mem_req_addr SHALL be: output, 32 bits, fetch address (word aligned).
REQ-006 Port mem_req_ready SHALL be: input, 1 bit, memory accepts the request.
REQ-007 Port mem_rsp_valid SHALL be: input, 1 bit, response data valid.
REQ-008 Port mem_rsp_data SHALL be: input, 32 bits, fetched instruction word.
REQ-009 Port mem_rsp_err SHALL be: input, 1 bit, access fault; qualified by mem_rsp_valid.
REQ-010 Port inst_valid SHALL be: output, 1 bit, the instruction is offered to the execute stage.
REQ-011 Port inst SHALL be: output, 32 bits, the held instruction word.
REQ-012 Port inst_pc SHALL be: output, 32 bits, the address of inst.
REQ-013 Port inst_ready SHALL be: input, 1 bit, the execute stage consumes inst.
REQ-014 Port pc_upd_valid SHALL be: input, 1 bit, the execute stage presents the next PC.
REQ-015 Port pc_upd SHALL be: input, 32 bits, the next PC (static PC+4 or branch/jump target).
REQ-016 Port fetch_err SHALL be: output, 1 bit, sticky fault flag.

Function
REQ-017 The FSM SHALL have exactly the states REQ, WAIT, HOLD, NEXT and ERR.
REQ-018 In REQ: mem_req_valid=1 and mem_req_addr=pc; on mem_req_ready the FSM SHALL go to WAIT; mem_rsp_valid SHALL be ignored.
REQ-019 In WAIT, on mem_rsp_valid with mem_rsp_err=0, the IFU SHALL latch inst<=mem_rsp_data and inst_pc<=pc and go to HOLD.
REQ-020 In WAIT, on mem_rsp_valid with mem_rsp_err=1, the FSM SHALL go to ERR.
REQ-021 In HOLD, inst_valid SHALL be 1 and inst/inst_pc SHALL stay stable until inst_ready; on inst_ready the FSM SHALL go to NEXT.
REQ-022 In NEXT, on pc_upd_valid the IFU SHALL load pc<=pc_upd and go to REQ.
REQ-023 With inst_ready and pc_upd_valid in the same HOLD cycle, the IFU SHALL load pc<=pc_upd and go directly to REQ.
REQ-024 pc_upd_valid SHALL be ignored in REQ, WAIT and ERR, and in HOLD without inst_ready.
REQ-025 A pc_upd with pc_upd[1:0]!=0 that would be accepted SHALL send the FSM to ERR without issuing a fetch.
REQ-026 In ERR: fetch_err=1, mem_req_valid=0 and inst_valid=0; ERR SHALL be left only by rst.
REQ-027 Each accepted request SHALL receive exactly one response; at most one fetch SHALL be outstanding.
REQ-028 Minimum latency SHALL be: request accepted in cycle N -> response in cycle N+1 or later -> inst_valid in the following cycle.
REQ-029 pc SHALL wrap modulo 2^32 with no special handling.

Reset
REQ-030 rst sampled high SHALL give: state=REQ, pc=RESET_PC, inst=32'h0, inst_pc=32'h0, fetch_err=0.
REQ-031 rst asserted mid-operation SHALL abandon any outstanding fetch and resume from the reset state.
REQ-032 The instruction memory SHALL share this rst, so no stale response arrives after reset.
REQ-033 In the first cycle after rst deasserts, outputs SHALL be mem_req_valid=1 and mem_req_addr=RESET_PC.

Structure
REQ-034 The FSM state encodings and the RESET_PC default SHALL reside in the shared package ysyx_24100005_defs.
REQ-035 The PC register SHALL be an instance of the existing sub-module ysyx_24100005_Reg (width 32, reset value RESET_PC, wen=pc load).

Verification
REQ-036 Reset, mem_req_ready=1, response one cycle later with 32'h00100093 -> inst_valid=1 in cycle 2, inst=32'h00100093, inst_pc=32'h8000_0000.
REQ-037 mem_req_ready held low for 3 cycles -> mem_req_valid/addr stable, then WAIT; inst_ready low for 4 cycles -> inst stable, no new request.
REQ-038 HOLD with inst_ready=1 and pc_upd_valid=1 (pc_upd=32'h8000_0010) together -> next cycle REQ with mem_req_addr=32'h8000_0010.
REQ-039 mem_rsp_err=1, or pc_upd=32'h8000_0002 accepted -> fetch_err=1 and no further requests; rst -> fetch restarts at 32'h8000_0000.
REQ-040 rst asserted in WAIT -> next cycle REQ at RESET_PC; pc_upd=32'hFFFF_FFFC then 32'h0000_0000 -> addresses wrap correctly.
